sequencer_fsa: RTL and testbench
================================

# sequencer_fsa

Finite-state sequencer that produces the timing backbone of the sequencer unit. It steps a 24-state one-hot FSA once per clock and decodes the derived pulses pA..pT from it. It truncates each instruction cycle when the instruction decoder returns abort8/abort10/abort12/abort14, and stops on halt. It sits directly upstream of the instruction decoder: it drives the decoder's `fsa_in` and derived-pulse inputs, and it consumes the decoder's abort and halt outputs.

## Interface
- NUM_STATES, 24, FSA length (a full, unaborted instruction cycle)
- COUNT_W, 16, width of the completed-instruction counter
- clock  in  1  system clock; all state changes on its rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  level; starts sequencing when idle
- halt  in  1  level from the instruction decoder; sampled only in the terminal state
- abort8, abort10, abort12, abort14  in  1 each  cycle-length requests from the instruction decoder
- fsa_out  out  NUM_STATES  one-hot FSA state; bit k high in state Sk; all zero when idle
- pulse  out  20  derived pulses; bit 0 = pA ... bit 19 = pT
- running  out  1  high while not idle
- instr_done  out  1  one-cycle strobe in the terminal state of each instruction
- instr_count  out  COUNT_W  number of completed instructions

## Operation
- Two modes: IDLE and RUN. RUN holds a state index s in 0..23.
- IDLE behaviour:
  - fsa_out = 0, pulse = 0, running = 0, instr_done = 0.
  - When run = 1, the next state is RUN with s = 0.
- RUN behaviour:
  - running = 1 and fsa_out = 1 << s.
  - pulse[n] = 1 exactly when s == n+1, for n = 0..19. S0 and S21..S23 carry no pulse.
- Terminal state:
  - s = 7 with abort8 = 1; s = 9 with abort10 = 1; s = 11 with abort12 = 1; s = 13 with abort14 = 1; or s = 23.
  - An abort input asserted in any other state is ignored.
  - If several aborts are high together, only the one matching the current s has effect.
- Next state:
  - In a non-terminal state: s + 1.
  - In a terminal state: if halt = 1, go to IDLE; otherwise s = 0 (start the next instruction).
  - halt has priority over run. run is not re-sampled in the terminal state.
- instr_done = 1 in every terminal state, including a halting one.
- instr_count increments by 1 in every terminal state. It wraps from 2^COUNT_W-1 to 0 and holds while idle.
- Reset:
  - Forces IDLE with instr_count = 0.
  - An asserted reset mid-instruction abandons that instruction: no instr_done, no count.
  - If reset and run are both high, reset wins.

## Timing
- State is registered. fsa_out, pulse, running and instr_done are combinational decodes of the registered state, valid in the same cycle.
- run sampled high at edge t: S0 is visible after edge t; pA is visible after edge t+1.
- Instruction length in cycles: 8 (abort8), 10, 12, 14, or 24 (no abort).
- Back-to-back instructions have no idle gap: the terminal state is followed immediately by S0.
- Halt: the terminal state is followed by IDLE on the next cycle. running falls one cycle after instr_done.
- instr_count updates on the edge that leaves the terminal state.

## Configuration
- SEQUENCER_SINGLE_STEP_EN defined:
  - Adds ports `step_mode` (in, 1) and `step` (in, 1).
  - While RUN and step_mode = 1, the state, instr_count and all transitions advance only on cycles with step = 1. Otherwise the state holds and the outputs stay static.
  - instr_done stays asserted for as long as the FSA holds in the terminal state; instr_count still increments once, on the advancing edge.
  - In IDLE, run is honoured regardless of step.
- Not defined: the ports are absent and RUN advances every cycle.

## Structure
- Shared package `sequencer_pkg` holds:
  - NUM_STATES = 24 and NUM_PULSES = 20
  - the typedef for the state index (5 bits)
  - a mode enum {SEQ_IDLE, SEQ_RUN}
  - terminal-index constants ABORT8_LAST = 7, ABORT10_LAST = 9, ABORT12_LAST = 11, ABORT14_LAST = 13
  - the pulse bit positions PA..PT
- One sub-module, `sequencer_pulse_decode`: a combinational map from state index and running to fsa_out and pulse.

## Test plan
- Reset held 3 cycles with run = 1 → fsa_out = 0, pulse = 0, running = 0, instr_count = 0 throughout.
- run pulsed once, no aborts, halt = 0 → S0..S23 repeating. pA high 1 cycle after S0; pT high in S20. instr_done at S23; instr_count = 1 after the first cycle and 2 after the second.
- abort8 held high from S0 → 8-cycle instructions (S7 → S0). Each instruction gives instr_done once and one count increment.
- abort8 high only at S9 and abort12 high at S11 in the same instruction → abort8 ignored; terminal at S11, 12-cycle instruction.
- halt = 1 throughout, abort14 at S13 → terminal at S13, then IDLE; running = 0 next cycle. Raising run again restarts at S0.
- instr_count preloaded to 0xFFFF by running 65535 instructions (abort8) → next terminal state wraps it to 0x0000.
- With SEQUENCER_SINGLE_STEP_EN, step_mode = 1 → the state holds at S3 for 5 cycles with step = 0, then advances to S4 on a single step = 1 cycle.
- Reset asserted at S5 → IDLE next cycle, instr_count unchanged at 0, no instr_done.

Source files
------------

// File: rtl/sequencer_pkg.sv
// Shared types and constants for the 24-state sequencer FSA.
// Optional single-step mode is enabled by SEQUENCER_SINGLE_STEP_EN.
package sequencer_pkg;

    localparam int NUM_STATES = 24;
    localparam int NUM_PULSES = 20;

    typedef logic [4:0] state_idx_t;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_RUN
    } mode_e;

    localparam state_idx_t ABORT8_LAST  = 5'd7;
    localparam state_idx_t ABORT10_LAST = 5'd9;
    localparam state_idx_t ABORT12_LAST = 5'd11;
    localparam state_idx_t ABORT14_LAST = 5'd13;
    localparam state_idx_t LAST_STATE   = 5'd23;

    localparam int PA = 0;
    localparam int PB = 1;
    localparam int PC = 2;
    localparam int PD = 3;
    localparam int PE = 4;
    localparam int PF = 5;
    localparam int PG = 6;
    localparam int PH = 7;
    localparam int PI = 8;
    localparam int PJ = 9;
    localparam int PK = 10;
    localparam int PL = 11;
    localparam int PM = 12;
    localparam int PN = 13;
    localparam int PO = 14;
    localparam int PP = 15;
    localparam int PQ = 16;
    localparam int PR = 17;
    localparam int PS = 18;
    localparam int PT = 19;

    // An abort only ends the cycle in the one state it is tied to.
    function automatic logic is_terminal(
        input state_idx_t s,
        input logic       a8,
        input logic       a10,
        input logic       a12,
        input logic       a14
    );
        return (s == LAST_STATE)
            || (s == ABORT8_LAST  && a8)
            || (s == ABORT10_LAST && a10)
            || (s == ABORT12_LAST && a12)
            || (s == ABORT14_LAST && a14);
    endfunction

endpackage

// File: rtl/sequencer_pulse_decode.sv
// Combinational decode of the state index into one-hot FSA and pA..pT.
module sequencer_pulse_decode
    import sequencer_pkg::*;
(
    input  logic                  running_i,
    input  state_idx_t            state_i,
    output logic [NUM_STATES-1:0] fsa_o,
    output logic [NUM_PULSES-1:0] pulse_o
);

    always_comb begin
        fsa_o = '0;
        for (int k = 0; k < NUM_STATES; k++) begin
            fsa_o[k] = running_i && (state_i == state_idx_t'(k));
        end
    end

    // pA follows S0 by one state, so pulse n lives in state n+1.
    always_comb begin
        pulse_o = '0;
        for (int n = 0; n < NUM_PULSES; n++) begin
            pulse_o[n] = running_i && (state_i == state_idx_t'(n + 1));
        end
    end

endmodule

// File: rtl/sequencer_fsa.sv
// Sequencer timing backbone: 24-state FSA with abort truncation and halt.
// Define SEQUENCER_SINGLE_STEP_EN to add step_mode/step single-stepping.
module sequencer_fsa
    import sequencer_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  halt,
    input  logic                  abort8,
    input  logic                  abort10,
    input  logic                  abort12,
    input  logic                  abort14,
`ifdef SEQUENCER_SINGLE_STEP_EN
    input  logic                  step_mode,
    input  logic                  step,
`endif
    output logic [NUM_STATES-1:0] fsa_out,
    output logic [NUM_PULSES-1:0] pulse,
    output logic                  running,
    output logic                  instr_done,
    output logic [COUNT_W-1:0]    instr_count
);

    mode_e              mode_q, mode_d;
    state_idx_t         s_q, s_d;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    logic               adv;
    logic               term;

`ifdef SEQUENCER_SINGLE_STEP_EN
    assign adv = !step_mode || step;
`else
    assign adv = 1'b1;
`endif

    assign running     = (mode_q == SEQ_RUN);
    assign term        = running
                      && is_terminal(s_q, abort8, abort10, abort12, abort14);
    assign instr_done  = term;
    assign instr_count = cnt_q;

    always_comb begin
        mode_d = mode_q;
        s_d    = s_q;
        cnt_d  = cnt_q;
        unique case (mode_q)
            SEQ_IDLE: begin
                if (run) begin
                    mode_d = SEQ_RUN;
                    s_d    = '0;
                end
            end
            SEQ_RUN: begin
                if (adv) begin
                    if (term) begin
                        cnt_d = cnt_q + COUNT_W'(1);
                        s_d   = '0;
                        // run is not re-sampled here; halt alone decides
                        if (halt) begin
                            mode_d = SEQ_IDLE;
                        end
                    end else begin
                        s_d = s_q + 5'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q <= SEQ_IDLE;
            s_q    <= '0;
            cnt_q  <= '0;
        end else begin
            mode_q <= mode_d;
            s_q    <= s_d;
            cnt_q  <= cnt_d;
        end
    end

    sequencer_pulse_decode u_decode (
        .running_i (running),
        .state_i   (s_q),
        .fsa_o     (fsa_out),
        .pulse_o   (pulse)
    );

endmodule

// File: tb/tb_sequencer_fsa.sv
// Directed table-driven bench for sequencer_fsa.
module tb_sequencer_fsa;

    localparam int CW = 8;

    logic          clock = 1'b0;
    logic          reset;
    logic          run;
    logic          halt;
    logic          abort8;
    logic          abort10;
    logic          abort12;
    logic          abort14;
`ifdef SEQUENCER_SINGLE_STEP_EN
    logic          step_mode;
    logic          step;
`endif
    logic [23:0]   fsa_out;
    logic [19:0]   pulse;
    logic          running;
    logic          instr_done;
    logic [CW-1:0] instr_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic       run;
        logic       halt;
        logic [3:0] ab;
        logic       exp_run;
        int         exp_s;
        logic       exp_done;
        int         exp_cnt;
    } vec_t;

    vec_t tv[$];

    sequencer_fsa #(.COUNT_W(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .halt        (halt),
        .abort8      (abort8),
        .abort10     (abort10),
        .abort12     (abort12),
        .abort14     (abort14),
`ifdef SEQUENCER_SINGLE_STEP_EN
        .step_mode   (step_mode),
        .step        (step),
`endif
        .fsa_out     (fsa_out),
        .pulse       (pulse),
        .running     (running),
        .instr_done  (instr_done),
        .instr_count (instr_count)
    );

    always #5 clock = ~clock;

    function automatic void add(input logic r, input logic rn, input logic h,
                                input logic [3:0] ab, input logic er,
                                input int es, input logic ed, input int ec);
        vec_t v;
        v.rst = r; v.run = rn; v.halt = h; v.ab = ab;
        v.exp_run = er; v.exp_s = es; v.exp_done = ed; v.exp_cnt = ec;
        tv.push_back(v);
    endfunction

    function automatic logic [23:0] fsa_of(input logic r, input int s);
        logic [23:0] one = 24'd1;
        return r ? (one << s) : 24'd0;
    endfunction

    function automatic logic [19:0] pulse_of(input logic r, input int s);
        logic [19:0] one = 20'd1;
        return (r && s >= 1 && s <= 20) ? (one << (s - 1)) : 20'd0;
    endfunction

    task automatic check(input string nm, input logic er, input int es,
                         input logic ed, input int ec);
        logic [23:0]   ef;
        logic [19:0]   ep;
        logic [CW-1:0] cnt;
        ef  = fsa_of(er, es);
        ep  = pulse_of(er, es);
        cnt = CW'(ec);
        n_cmp++;
        if (fsa_out !== ef || pulse !== ep || running !== er
            || instr_done !== ed || instr_count !== cnt) begin
            n_bad++;
            $display("FAIL %s: got fsa=%h pulse=%h run=%b done=%b cnt=%h want fsa=%h pulse=%h run=%b done=%b cnt=%h",
                     nm, fsa_out, pulse, running, instr_done, instr_count,
                     ef, ep, er, ed, cnt);
        end
    endtask

    task automatic set_in(input logic r, input logic rn, input logic h,
                          input logic [3:0] ab);
        reset = r; run = rn; halt = h;
        abort8 = ab[0]; abort10 = ab[1]; abort12 = ab[2]; abort14 = ab[3];
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // reset held with run high
        for (int i = 0; i < 3; i++) add(1, 1, 0, 4'h0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0, 0, 0, 0, 0);
        // two full unaborted instructions
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 24; s++)
                add(0, 0, 0, 4'h0, 1, s, s == 23, i);
        // abort8 held: two 8-cycle instructions
        for (int i = 0; i < 2; i++)
            for (int s = 0; s < 8; s++)
                add(0, 0, 0, 4'h1, 1, s, s == 7, 2 + i);
        // stray aborts at S1 and S9 ignored, abort12 ends at S11
        for (int s = 0; s < 12; s++)
            add(0, 0, 0, (s == 1) ? 4'hF : (s == 9) ? 4'h1 :
                         (s == 11) ? 4'h4 : 4'h0,
                1, s, s == 11, 4);
        // halt throughout, abort14 at S13
        for (int s = 0; s < 14; s++)
            add(0, 0, 1, (s == 13) ? 4'h8 : 4'h0, 1, s, s == 13, 5);
        add(0, 0, 1, 4'h0, 0, 0, 0, 6);
        add(0, 1, 1, 4'h0, 0, 0, 0, 6);
        // restart, then reset at S5 clears count
        for (int s = 0; s < 5; s++) add(0, 0, 0, 4'h0, 1, s, 0, 6);
        add(1, 0, 0, 4'h0, 1, 5, 0, 6);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0);
        // reset at S5 with count at 0: no done, count stays 0
        add(0, 1, 0, 4'h0, 0, 0, 0, 0);
        for (int s = 0; s < 5; s++) add(0, 0, 0, 4'h0, 1, s, 0, 0);
        add(1, 0, 0, 4'h0, 1, 5, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0);

`ifdef SEQUENCER_SINGLE_STEP_EN
        step_mode = 1'b0;
        step      = 1'b0;
`endif
        set_in(1, 0, 0, 4'h0);
        tick();
        foreach (tv[i]) begin
            set_in(tv[i].rst, tv[i].run, tv[i].halt, tv[i].ab);
            @(negedge clock);
            check($sformatf("vec%0d", i), tv[i].exp_run, tv[i].exp_s,
                  tv[i].exp_done, tv[i].exp_cnt);
            tick();
        end

        // counter wrap with abort8 instructions
        set_in(1, 0, 0, 4'h0);
        tick();
        set_in(0, 1, 0, 4'h1);
        tick();
        run = 1'b0;
        repeat (255 * 8) tick();
        @(negedge clock);
        check("wrap_pre", 1, 0, 0, 255);
        repeat (7) tick();
        @(negedge clock);
        check("wrap_term", 1, 7, 1, 255);
        tick();
        @(negedge clock);
        check("wrap_zero", 1, 0, 0, 0);

`ifdef SEQUENCER_SINGLE_STEP_EN
        set_in(1, 0, 0, 4'h0);
        tick();
        set_in(0, 1, 0, 4'h0);
        tick();
        run = 1'b0;
        repeat (3) tick();
        step_mode = 1'b1;
        step      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("step_hold%0d", i), 1, 3, 0, 0);
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        @(negedge clock);
        check("step_adv", 1, 4, 0, 0);
        tick();
        @(negedge clock);
        check("step_hold_s4", 1, 4, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
